// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU and its result register among NREQ requesters.
// Optional macro ALU_ARB_RR_EN selects round-robin arbitration (default: fixed priority).
module alu_share_ctrl #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    input  logic [NREQ*2-1:0]     opcode,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [1:0]            alu_op,
    input  logic [WIDTH-1:0]      alu_y,
    output logic                  reg_load,
    output logic [WIDTH-1:0]      res_q,
    output logic [IDW-1:0]        res_id,
    output logic                  res_valid,
    input  logic                  res_ready
);

    localparam int unsigned N = NREQ;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state, state_d;
    logic [IDW-1:0]   win;
    logic             found;
    logic [IDW-1:0]   win_q, win_q_d;
    logic [NREQ-1:0]  gnt_d;
    logic             busy_d, reg_load_d, res_valid_d;
    logic [WIDTH-1:0] alu_a_d, alu_b_d, res_q_d;
    logic [1:0]       alu_op_d;
    logic [IDW-1:0]   res_id_d;

    logic [WIDTH-1:0] a_arr  [NREQ];
    logic [WIDTH-1:0] b_arr  [NREQ];
    logic [1:0]       op_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign a_arr[g]  = op_a[g*WIDTH +: WIDTH];
        assign b_arr[g]  = op_b[g*WIDTH +: WIDTH];
        assign op_arr[g] = opcode[g*2 +: 2];
    end

`ifdef ALU_ARB_RR_EN
    logic [IDW-1:0] ptr, ptr_d;

    // Search starts at the pointer and wraps back to index 0.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end
`else
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req[IDW'(k)]) begin
                found = 1'b1;
                win   = IDW'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d     = state;
        win_q_d     = win_q;
        gnt_d       = '0;
        reg_load_d  = 1'b0;
        res_valid_d = res_valid;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_op_d    = alu_op;
        res_q_d     = res_q;
        res_id_d    = res_id;
`ifdef ALU_ARB_RR_EN
        ptr_d       = ptr;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_d    = EXEC;
                    win_q_d    = win;
                    gnt_d      = NREQ'(1) << win;
                    reg_load_d = 1'b1;
                    alu_a_d    = a_arr[win];
                    alu_b_d    = b_arr[win];
                    alu_op_d   = op_arr[win];
`ifdef ALU_ARB_RR_EN
                    ptr_d      = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
`endif
                end
            end
            EXEC: begin
                state_d     = DONE;
                res_q_d     = alu_y;
                res_id_d    = win_q;
                res_valid_d = 1'b1;
            end
            DONE: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            win_q     <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            reg_load  <= 1'b0;
            res_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_q     <= '0;
            res_id    <= '0;
`ifdef ALU_ARB_RR_EN
            ptr       <= '0;
`endif
        end else begin
            state     <= state_d;
            win_q     <= win_q_d;
            gnt       <= gnt_d;
            busy      <= busy_d;
            reg_load  <= reg_load_d;
            res_valid <= res_valid_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_op    <= alu_op_d;
            res_q     <= res_q_d;
            res_id    <= res_id_d;
`ifdef ALU_ARB_RR_EN
            ptr       <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: transaction-level model plus directed literal checks.
// Build with ALU_ARB_RR_EN defined to exercise the round-robin arbiter.
module tb_alu_share_ctrl;

    localparam int NREQ  = 4;
    localparam int WIDTH = 2;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a, op_b;
    logic [NREQ*2-1:0]     opcode;
    logic [NREQ-1:0]       gnt;
    logic                  busy, reg_load, res_valid, res_ready;
    logic [WIDTH-1:0]      alu_a, alu_b, alu_y, res_q;
    logic [1:0]            alu_op;
    logic [IDW-1:0]        res_id;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .opcode(opcode),
        .gnt(gnt), .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .reg_load(reg_load), .res_q(res_q), .res_id(res_id),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    // External ALU: 0 add, 1 sub, 2 and, 3 xor, all mod 2^WIDTH.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_y = alu_fn(alu_a, alu_b, alu_op);

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int i;
`ifdef ALU_ARB_RR_EN
            i = (p + k) % NREQ;
`else
            i = k;
`endif
            if (r[i]) return i;
        end
        return 0;
    endfunction

    // Transaction-level model: one transaction in flight, granted, then presented until accepted.
    logic             m_busy, m_grant, m_valid;
    int               m_w, m_rid, m_ptr, m_pick;
    logic [WIDTH-1:0] m_a, m_b, m_res;
    logic [1:0]       m_op;

    assign m_pick = pick(req, m_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_grant <= 1'b0; m_valid <= 1'b0;
            m_w <= 0; m_rid <= 0; m_ptr <= 0;
            m_a <= '0; m_b <= '0; m_op <= '0; m_res <= '0;
        end else if (m_grant) begin
            m_grant <= 1'b0;
            m_valid <= 1'b1;
            m_res   <= alu_fn(m_a, m_b, m_op);
            m_rid   <= m_w;
        end else if (m_valid) begin
            if (res_ready) begin
                m_valid <= 1'b0;
                m_busy  <= 1'b0;
            end
        end else if (req != '0) begin
            m_busy  <= 1'b1;
            m_grant <= 1'b1;
            m_w     <= m_pick;
            m_a     <= WIDTH'(op_a >> (m_pick * WIDTH));
            m_b     <= WIDTH'(op_b >> (m_pick * WIDTH));
            m_op    <= 2'(opcode >> (m_pick * 2));
            m_ptr   <= (m_pick + 1) % NREQ;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_gnt", 32'(gnt), m_grant ? 32'(1) << m_w : 32'd0);
            chk("m_reg_load", 32'(reg_load), 32'(m_grant));
            chk("m_busy", 32'(busy), 32'(m_busy));
            chk("m_res_valid", 32'(res_valid), 32'(m_valid));
            chk("m_res_q", 32'(res_q), 32'(m_res));
            chk("m_res_id", 32'(res_id), 32'(m_rid));
            chk("m_alu_a", 32'(alu_a), 32'(m_a));
            chk("m_alu_b", 32'(alu_b), 32'(m_b));
            chk("m_alu_op", 32'(alu_op), 32'(m_op));
        end
    end

    task automatic wait_gnt(output int id, output int at);
        id = -1;
        at = 0;
        for (int n = 0; n < 20 && id < 0; n++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) if (gnt[i]) id = i;
        end
        at = cyc;
        if (id < 0) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_reg_load"}, 32'(reg_load), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_q"}, 32'(res_q), 32'd0);
        chk({tag, "_res_id"}, 32'(res_id), 32'd0);
        chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int id, at, prev;
        rst = 1'b1; req = '0; op_a = '0; op_b = '0; opcode = '0; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 1: 01 + 10 = 11.
        req = 4'b0010; op_a = 8'b0000_0100; op_b = 8'b0000_1000; opcode = '0;
        wait_gnt(id, at);
        chk("single_gnt", 32'(gnt), 32'b0010);
        chk("single_reg_load", 32'(reg_load), 32'd1);
        req = '0;
        @(negedge clk);
        chk("single_gnt_gone", 32'(gnt), 32'd0);
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_res_q", 32'(res_q), 32'b11);
        chk("single_res_id", 32'(res_id), 32'd1);
        @(negedge clk);

        // Backpressure: requester 0 computes 11 + 11 = 10, result held for 5 cycles.
        req = 4'b0001; op_a = 8'b0000_0011; op_b = 8'b0000_0011; res_ready = 1'b0;
        wait_gnt(id, at);
        chk("bp_first_id", 32'(id), 32'd0);
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_res_q", 32'(res_q), 32'b10);
            chk("bp_res_id", 32'(res_id), 32'd0);
            chk("bp_no_gnt", 32'(gnt), 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_busy", 32'(busy), 32'd0);
        chk("bp_idle_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        chk("bp_regrant", 32'(gnt), 32'b0001);
        req = '0;
        repeat (3) @(negedge clk);

`ifndef ALU_ARB_RR_EN
        // Fixed priority: requester 1 starves requester 3 while its req is held.
        req = 4'b1010;
        prev = -1;
        for (int n = 0; n < 3; n++) begin
            wait_gnt(id, at);
            chk("fp_id", 32'(id), 32'd1);
            if (prev >= 0) chk("fp_spacing", 32'(at - prev), 32'd3);
            prev = at;
        end
        req = 4'b1000;
        wait_gnt(id, at);
        chk("fp_id_after_drop", 32'(id), 32'd3);
        req = '0;
        repeat (3) @(negedge clk);
`else
        // Round robin from a freshly reset pointer, then wrap with sparse requests.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        prev = -1;
        for (int n = 0; n < 4; n++) begin
            wait_gnt(id, at);
            chk("rr_id", 32'(id), 32'(n));
            if (prev >= 0) chk("rr_spacing", 32'(at - prev), 32'd3);
            prev = at;
        end
        req = 4'b0101;
        wait_gnt(id, at);
        chk("rr_wrap_id", 32'(id), 32'd0);
        chk("rr_wrap_spacing", 32'(at - prev), 32'd3);
        wait_gnt(id, at);
        chk("rr_sparse_id", 32'(id), 32'd2);
        req = '0;
        repeat (3) @(negedge clk);
`endif

        // Reset during EXEC discards the transaction.
        req = 4'b0100; op_a = 8'b0011_0000; op_b = 8'b0001_0000; opcode = 8'b0001_0000;
        wait_gnt(id, at);
        rst = 1'b1;
        #1;
        check_all_zero("midop");
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("midop_no_valid", 32'(res_valid), 32'd0);
            chk("midop_no_busy", 32'(busy), 32'd0);
        end

        // Randomized traffic checked by the model.
        for (int n = 0; n < 3000; n++) begin
            req       = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if ($urandom_range(0, 3) == 0) req = '0;
            op_a      = (NREQ*WIDTH)'($urandom);
            op_b      = (NREQ*WIDTH)'($urandom);
            opcode    = (NREQ*2)'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
